// File: rtl/nn_ctrl_pkg.sv
// Shared neural-net controller definitions: mode encoding, valid-sequencer FSM states, width helper.
// Pure definitions, no timing; used by the top controller and the per-tile valid sequencer.
package nn_ctrl_pkg;

  localparam logic [2:0] MODE_IDLE  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_LAYER = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } vp_state_t;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/valid_pipeline_ctrl_if.sv
// Start/mode handshake plus row strobes and tile status between the top controller and the valid sequencer.
// Wires only; the sequencer side registers every output it drives and never stalls the controller.
interface valid_pipeline_ctrl_if #(
  parameter int N     = 4,
  parameter int ARRAY = 4
);
  localparam int TILE_W = nn_ctrl_pkg::idx_w(N / ARRAY);

  logic              start;
  logic [2:0]        mode;
  logic              busy;
  logic              next_tile_ready;
  logic [ARRAY-1:0]  row_valid;
  logic              result_valid;
  logic [TILE_W-1:0] tile_idx;
  logic              tiles_done;

  modport master (
    output start, mode,
    input  busy, next_tile_ready, row_valid, result_valid, tile_idx, tiles_done
  );

  modport slave (
    input  start, mode,
    output busy, next_tile_ready, row_valid, result_valid, tile_idx, tiles_done
  );

endinterface

// File: rtl/valid_skew_line.sv
// Delays the row-0 valid by 1..ARRAY-1 cycles to feed rows 1..ARRAY-1 (ARRAY >= 2).
// Latency r cycles for row r; no backpressure, flush empties the line on the next edge.
module valid_skew_line #(
  parameter int ARRAY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             din,
  output logic [ARRAY-1:1] dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (flush) begin
      dout <= '0;
    end else begin
      dout[1] <= din;
      for (int i = 2; i < ARRAY; i++) begin
        dout[i] <= dout[i-1];
      end
    end
  end

endmodule

// File: rtl/valid_pipeline_ctrl.sv
// Per-tile valid sequencer: row-skewed input strobes, drain wait, result flag and tile index tracking.
// busy one cycle after an accepted start, tile period K+2*ARRAY cycles; no backpressure, starts while busy are dropped.
module valid_pipeline_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int N     = 4,
  parameter int ARRAY = 4,
  parameter int K     = 4
) (
  input logic                 clk,
  input logic                 rst,
  valid_pipeline_ctrl_if.slave bus
);

  localparam int NUM_TILES = N / ARRAY;
  localparam int TW        = idx_w(NUM_TILES);
  localparam int CW        = $clog2(K + ARRAY);

  localparam logic [CW-1:0] STREAM_LAST = CW'(K + ARRAY - 2);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(ARRAY - 1);
  localparam logic [CW-1:0] K_C         = CW'(K);
  localparam logic [TW-1:0] TILE_LAST   = TW'(NUM_TILES - 1);

  vp_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tile_q, tile_d;
  logic             busy_q, busy_d;
  logic             ntr_q, ntr_d;
  logic             row0_q, row0_d;
  logic             res_q, res_d;
  logic             done_q, done_d;
  logic             abort;
  logic [ARRAY-1:1] skew_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
    ntr_d   = ntr_q;
    abort   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.mode == MODE_LOAD)) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
          ntr_d   = 1'b0;
        end
      end
      ST_STREAM: begin
        if (bus.mode != MODE_LOAD) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STREAM_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // A mode change on the final drain cycle still counts as an abort: the tile is not retired.
        if (bus.mode != MODE_LOAD) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ntr_d   = 1'b1;
          tile_d  = (tile_q == TILE_LAST) ? '0 : tile_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    busy_d = (state_d != ST_IDLE);
    row0_d = (state_d == ST_STREAM) && (cnt_d < K_C);
    res_d  = (state_d == ST_DRAIN) && (cnt_d == DRAIN_LAST);
    done_d = res_d && (tile_q == TILE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tile_q  <= '0;
      busy_q  <= 1'b0;
      ntr_q   <= 1'b0;
      row0_q  <= 1'b0;
      res_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      busy_q  <= busy_d;
      ntr_q   <= ntr_d;
      row0_q  <= row0_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  valid_skew_line #(
    .ARRAY (ARRAY)
  ) u_skew (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .din   (row0_q),
    .dout  (skew_q)
  );

  assign bus.busy            = busy_q;
  assign bus.next_tile_ready = ntr_q;
  assign bus.row_valid       = {skew_q, row0_q};
  assign bus.result_valid    = res_q;
  assign bus.tile_idx        = tile_q;
  assign bus.tiles_done      = done_q;

endmodule
